// File: rtl/joy_dir_filter_pkg.sv
// Shared definitions for the joystick direction conditioner:
// mode encoding, direction bit positions and the direction priority helper.
package joy_pkg;

  typedef enum logic [1:0] {
    JM_PASS    = 2'd0,
    JM_LAST4   = 2'd1,
    JM_FIRST4  = 2'd2,
    JM_CANCEL8 = 2'd3
  } joy_mode_e;

  localparam int JD_UP    = 3;
  localparam int JD_DOWN  = 2;
  localparam int JD_LEFT  = 1;
  localparam int JD_RIGHT = 0;

  localparam logic [3:0] MASK_IDLE = 4'hF;

  // One-hot of the highest-priority set direction (up > down > left > right).
  function automatic logic [3:0] pri4(input logic [3:0] x);
    logic [3:0] r;
    r = '0;
    if (x[JD_UP])         r[JD_UP]    = 1'b1;
    else if (x[JD_DOWN])  r[JD_DOWN]  = 1'b1;
    else if (x[JD_LEFT])  r[JD_LEFT]  = 1'b1;
    else if (x[JD_RIGHT]) r[JD_RIGHT] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/joy_dir_filter_chan.sv
// One direction channel: two-flop synchroniser, optional debounce,
// mode-dependent direction filtering and a registered output with change strobe.
module joy_dir_chan
  import joy_pkg::*;
#(
  parameter int DEB_CNT = 0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ce_i,
  input  logic [1:0] mode_i,
  input  logic [3:0] dir_i,
  output logic [3:0] dir_o,
  output logic       changed_o
);

  // Terminal count of the debounce counter; unused when debounce is bypassed.
  localparam logic [7:0] DEB_LAST = 8'((DEB_CNT > 0) ? (DEB_CNT - 1) : 0);

  logic [3:0] s1_q, s2_q;
  logic [3:0] cand_q, cand_d;
  logic [3:0] stable_q, stable_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] stable_prev_q;
  logic [3:0] mask_q, mask_d;
  logic [3:0] lock_q, lock_d, lock_n;
  logic [1:0] mode_d_q;
  logic [3:0] dir_q;
  logic       changed_q;

  logic [3:0] stable;
  logic [3:0] newp;
  logic       mode_chg;
  logic [3:0] out_n;

  // With debounce disabled the synchronised input is used directly.
  assign stable = (DEB_CNT == 0) ? s2_q : stable_q;

  // Debounce: a candidate must stay constant for DEB_CNT further ce samples.
  always_comb begin
    cand_d   = cand_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (ce_i) begin
      if (s2_q != cand_q) begin
        cand_d = s2_q;
        cnt_d  = '0;
      end else if (cand_q != stable_q) begin
        if (cnt_q == DEB_LAST) begin
          stable_d = cand_q;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Mode filtering: a mode change returns mask/lock to idle for this cycle's output.
  always_comb begin
    mode_chg = (mode_i != mode_d_q);
    newp     = stable & ~stable_prev_q;

    if (mode_chg)                    mask_d = MASK_IDLE;
    else if (newp != 4'd0)           mask_d = pri4(newp);
    else if ((stable & mask_q) == 0) mask_d = MASK_IDLE;
    else                             mask_d = mask_q;

    if (mode_chg || lock_q == 4'd0)  lock_n = pri4(stable);
    else if ((stable & lock_q) == 0) lock_n = 4'd0;
    else                             lock_n = lock_q;
    lock_d = mode_chg ? 4'd0 : lock_n;

    out_n = stable;
    case (joy_mode_e'(mode_i))
      JM_PASS:   out_n = stable;
      JM_LAST4:  out_n = pri4(stable & mask_d);
      JM_FIRST4: out_n = stable & lock_n;
      JM_CANCEL8: begin
        out_n = stable;
        if (stable[JD_UP] && stable[JD_DOWN]) begin
          out_n[JD_UP]   = 1'b0;
          out_n[JD_DOWN] = 1'b0;
        end
        if (stable[JD_LEFT] && stable[JD_RIGHT]) begin
          out_n[JD_LEFT]  = 1'b0;
          out_n[JD_RIGHT] = 1'b0;
        end
      end
      default:   out_n = stable;
    endcase
  end

  // State registers: synchroniser, debounce, filter memory and outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q          <= '0;
      s2_q          <= '0;
      cand_q        <= '0;
      stable_q      <= '0;
      cnt_q         <= '0;
      stable_prev_q <= '0;
      mask_q        <= MASK_IDLE;
      lock_q        <= '0;
      mode_d_q      <= '0;
      dir_q         <= '0;
      changed_q     <= 1'b0;
    end else begin
      s1_q          <= dir_i;
      s2_q          <= s1_q;
      cand_q        <= cand_d;
      stable_q      <= stable_d;
      cnt_q         <= cnt_d;
      stable_prev_q <= stable;
      mask_q        <= mask_d;
      lock_q        <= lock_d;
      mode_d_q      <= mode_i;
      dir_q         <= out_n;
      changed_q     <= (out_n != dir_q);
    end
  end

  assign dir_o     = dir_q;
  assign changed_o = changed_q;

endmodule

// File: rtl/joy_dir_filter.sv
// Multi-player joystick direction conditioner: NCH independent channels
// packed onto flat mode/direction buses.
module joy_dir_filter
  import joy_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int DEB_CNT = 0
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ce,
  input  logic [2*NCH-1:0] mode,
  input  logic [4*NCH-1:0] dir_in,
  output logic [4*NCH-1:0] dir_out,
  output logic [NCH-1:0]   changed
);

  // One conditioner per player, each on its own slice of the buses.
  for (genvar n = 0; n < NCH; n++) begin : g_chan
    joy_dir_chan #(
      .DEB_CNT (DEB_CNT)
    ) u_chan (
      .clk_i     (clk_sys),
      .rst_i     (reset),
      .ce_i      (ce),
      .mode_i    (mode[2*n +: 2]),
      .dir_i     (dir_in[4*n +: 4]),
      .dir_o     (dir_out[4*n +: 4]),
      .changed_o (changed[n])
    );
  end

endmodule

// File: tb/tb_joy_dir_filter.sv
// Bench for joy_dir_filter: a two-channel instance without debounce and a
// one-channel instance with DEB_CNT=3. Expected output changes are queued
// as {cycle, value} and matched whenever a channel pulses changed.
module tb_joy_dir_filter;

  localparam int W = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;
  int   cyc = 0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ce is sampled high on every edge whose number is a multiple of 4
  initial forever begin
    @(posedge clk);
    #1;
    ce = (((cyc + 1) % 4) == 0);
  end

  // ---------------- DUTs ----------------
  logic [3:0] mode0   = 4'b0100;   // ch1 LAST4, ch0 PASS
  logic [7:0] dir_in0 = 8'd0;
  logic [7:0] dir_out0;
  logic [1:0] changed0;

  logic [1:0] mode1   = 2'b00;
  logic [3:0] dir_in1 = 4'd0;
  logic [3:0] dir_out1;
  logic [0:0] changed1;

  joy_dir_filter #(.NCH(2), .DEB_CNT(0)) dut0 (
    .clk_sys (clk),
    .reset   (rst),
    .ce      (ce),
    .mode    (mode0),
    .dir_in  (dir_in0),
    .dir_out (dir_out0),
    .changed (changed0)
  );

  joy_dir_filter #(.NCH(1), .DEB_CNT(3)) dut1 (
    .clk_sys (clk),
    .reset   (rst),
    .ce      (ce),
    .mode    (mode1),
    .dir_in  (dir_in1),
    .dir_out (dir_out1),
    .changed (changed1)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q0[$];   // dut0 channel 0
  logic [W-1:0] exp_q1[$];   // dut0 channel 1
  logic [W-1:0] exp_q2[$];   // dut1 channel 0
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%05h, expected 0x%05h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int s, input logic [3:0] v, input int at);
    logic [W-1:0] e;
    e = {at[15:0], v};
    case (s)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  task automatic pop_check(input int s, input string name, input logic [3:0] act);
    logic [W-1:0] e;
    bit have;
    have = 1'b0;
    e = '0;
    case (s)
      0:       if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
      1:       if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
      default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: unexpected change to %b at cycle %0d, expected no change", name, act, cyc);
    end else begin
      check({name, " {cycle,dir}"}, {cyc[15:0], act}, e);
    end
  endtask

  // Monitor: every change strobe must match the next expected {cycle, value}.
  always @(negedge clk) begin
    if (!rst) begin
      if (changed0[0]) pop_check(0, "dut0.ch0", dir_out0[3:0]);
      if (changed0[1]) pop_check(1, "dut0.ch1", dir_out0[7:4]);
      if (changed1[0]) pop_check(2, "dut1.ch0", dir_out1);
    end
  end

  // ---------------- driver tasks ----------------
  // Return #1 after the posedge that brings cyc to k.
  task automatic wait_to(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a channel of dut0 right after edge k; no-debounce latency is 3 edges.
  task automatic drive0(input int k, input int ch, input logic [3:0] v);
    wait_to(k);
    dir_in0[4*ch +: 4] = v;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset state
    wait_to(2);
    check("reset dir_out0", W'(dir_out0), W'(0));
    check("reset changed0", W'(changed0), W'(0));
    check("reset dir_out1", W'(dir_out1), W'(0));
    check("reset changed1", W'(changed1), W'(0));
    rst = 1'b0;

    // PASS on ch0
    drive0(10, 0, 4'b1010); push(0, 4'b1010, 13);
    drive0(16, 0, 4'b0000); push(0, 4'b0000, 19);

    // LAST4 on ch1
    drive0(20, 1, 4'b1000); push(1, 4'b1000, 23);
    drive0(26, 1, 4'b1001); push(1, 4'b0001, 29);  // right pressed last
    drive0(32, 1, 4'b1000); push(1, 4'b1000, 35);  // right released, mask idles
    drive0(38, 1, 4'b0000); push(1, 4'b0000, 41);
    drive0(44, 1, 4'b0110); push(1, 4'b0100, 47);  // simultaneous: down beats left
    drive0(50, 1, 4'b0011); push(1, 4'b0001, 53);  // release down + press right
    drive0(56, 1, 4'b0000); push(1, 4'b0000, 59);

    // FIRST4 on ch0
    wait_to(60); mode0[1:0] = 2'd2;
    drive0(64, 0, 4'b0010); push(0, 4'b0010, 67);
    drive0(70, 0, 4'b1010);                        // up ignored while left held
    drive0(76, 0, 4'b1000); push(0, 4'b0000, 79); push(0, 4'b1000, 80);
    drive0(84, 0, 4'b0000); push(0, 4'b0000, 87);

    // CANCEL8 on ch0
    wait_to(90); mode0[1:0] = 2'd3;
    drive0(94, 0, 4'b1101);  push(0, 4'b0001, 97);
    drive0(100, 0, 4'b1111); push(0, 4'b0000, 103);
    drive0(106, 0, 4'b0110); push(0, 4'b0110, 109);
    drive0(112, 0, 4'b0000); push(0, 4'b0000, 115);

    // ch1 LAST4 holding right, then up added, then switched to PASS
    drive0(120, 1, 4'b0001); push(1, 4'b0001, 123);
    drive0(126, 1, 4'b1001); push(1, 4'b1000, 129);
    wait_to(134); mode0[3:2] = 2'd0; push(1, 4'b1001, 135);

    // asynchronous reset mid-hold
    wait_to(139);
    check("hold before reset", W'(dir_out0), W'(8'b1001_0000));
    wait_to(140);
    rst = 1'b1;
    #1;
    check("async reset dir_out0", W'(dir_out0), W'(0));
    check("async reset changed0", W'(changed0), W'(0));
    wait_to(143);
    rst = 1'b0;
    push(1, 4'b1001, 146);                         // 3 clocks after release
    drive0(150, 1, 4'b0000); push(1, 4'b0000, 153);

    // debounce (DEB_CNT=3, ce on edges 4m)
    wait_to(160); dir_in1 = 4'b0100;               // sampled by ce at 164, 168
    wait_to(168); dir_in1 = 4'b0000;               // gone by ce at 172: filtered
    wait_to(180); dir_in1 = 4'b0100;               // ce 184,188,192,196 -> out at 197
    push(2, 4'b0100, 197);
    wait_to(200); dir_in1 = 4'b0000;               // ce 204..216 -> out at 217
    push(2, 4'b0000, 217);

    // every expected change must have been seen
    wait_to(230);
    check("dut0.ch0 leftover", W'(exp_q0.size()), W'(0));
    check("dut0.ch1 leftover", W'(exp_q1.size()), W'(0));
    check("dut1.ch0 leftover", W'(exp_q2.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
